// File: rtl/rand_coord_gen.sv
// -----------------------------------------------------------------------------
// rand_coord_gen
//
// Produces pseudo-random on-screen coordinates snapped to a grid. A free-running
// Fibonacci LFSR supplies candidate cell indices. On a request the FSM draws up
// to MAX_TRY candidates, accepts the first one that lands inside the grid, and
// otherwise clamps the last candidate into the grid. The pixel coordinate is
// X_MIN + ix*GRID / Y_MIN + iy*GRID.
//
// Ports:
//   VGA_clk    in   1       sole clock, rising edge
//   rst_n      in   1       asynchronous, active-low reset
//   req        in   1       request a new coordinate pair (sampled on the edge)
//   rand_X     out  X_W     registered X coordinate
//   rand_Y     out  Y_W     registered Y coordinate
//   valid      out  1       one-cycle pulse, new rand_X/rand_Y presented (DONE)
//   busy       out  1       high while drawing (DRAW)
//
// Optional feature (macro RAND_COORD_RESEED_EN):
//   seed_load  in   1       load seed_i into the LFSR on the next edge
//   seed_i     in   LFSR_W  new LFSR value (zero maps to SEED)
// -----------------------------------------------------------------------------
module rand_coord_gen #(
    parameter int                X_W     = 10,
    parameter int                Y_W     = 9,
    parameter int                LFSR_W  = 16,
    parameter logic [LFSR_W-1:0] SEED    = 16'hACE1,
    parameter logic [LFSR_W-1:0] TAPS    = 16'hB400,
    parameter int                CELL_W  = 6,
    parameter int                X_MIN   = 20,
    parameter int                X_CELLS = 61,
    parameter int                Y_MIN   = 20,
    parameter int                Y_CELLS = 45,
    parameter int                GRID    = 10,
    parameter int                MAX_TRY = 8
) (
    input  logic              VGA_clk,
    input  logic              rst_n,
    input  logic              req,
    output logic [X_W-1:0]    rand_X,
    output logic [Y_W-1:0]    rand_Y,
    output logic              valid,
    output logic              busy
`ifdef RAND_COORD_RESEED_EN
    ,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_i
`endif
);

    localparam int                TRY_W    = (MAX_TRY > 1) ? $clog2(MAX_TRY) : 1;
    localparam logic [TRY_W-1:0]  TRY_LAST = TRY_W'(MAX_TRY - 1);
    localparam logic [CELL_W-1:0] X_LAST   = CELL_W'(X_CELLS - 1);
    localparam logic [CELL_W-1:0] Y_LAST   = CELL_W'(Y_CELLS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_t;

    // Parity of the tapped bits forms the feedback bit.
    function automatic logic lfsr_fb(input logic [LFSR_W-1:0] v);
        return ^(v & TAPS);
    endfunction

    state_t              state_r;
    state_t              state_s;
    logic [TRY_W-1:0]    try_cnt_r;
    logic [TRY_W-1:0]    try_cnt_s;
    logic [LFSR_W-1:0]   lfsr_r;
    logic [LFSR_W-1:0]   lfsr_s;
    logic [X_W-1:0]      rand_x_r;
    logic [Y_W-1:0]      rand_y_r;
    logic                valid_r;
    logic                busy_r;
    logic                load_s;

    logic [CELL_W-1:0]   ix_s;
    logic [CELL_W-1:0]   iy_s;
    logic                x_in_s;
    logic                y_in_s;
    logic [CELL_W-1:0]   ix_sel_s;
    logic [CELL_W-1:0]   iy_sel_s;
    logic [X_W-1:0]      x_calc_s;
    logic [Y_W-1:0]      y_calc_s;

    assign ix_s   = lfsr_r[CELL_W-1:0];
    assign iy_s   = lfsr_r[2*CELL_W-1:CELL_W];
    assign x_in_s = (ix_s <= X_LAST);
    assign y_in_s = (iy_s <= Y_LAST);

    // In-range indices pass through; out-of-range ones clamp to the last cell.
    // On an accept both are in range, so one path serves accept and clamp.
    assign ix_sel_s = x_in_s ? ix_s : X_LAST;
    assign iy_sel_s = y_in_s ? iy_s : Y_LAST;

    // Arithmetic at port width; the parameters keep the result in range.
    assign x_calc_s = X_W'(X_MIN) + X_W'(ix_sel_s) * X_W'(GRID);
    assign y_calc_s = Y_W'(Y_MIN) + Y_W'(iy_sel_s) * Y_W'(GRID);

    // LFSR next value: optional reseed, zero-state recovery, else shift.
    always_comb begin
        lfsr_s = {lfsr_r[LFSR_W-2:0], lfsr_fb(lfsr_r)};
`ifdef RAND_COORD_RESEED_EN
        if (seed_load) begin
            lfsr_s = (seed_i == {LFSR_W{1'b0}}) ? SEED : seed_i;
        end else if (lfsr_r == {LFSR_W{1'b0}}) begin
            lfsr_s = SEED;
        end else begin
            lfsr_s = {lfsr_r[LFSR_W-2:0], lfsr_fb(lfsr_r)};
        end
`else
        if (lfsr_r == {LFSR_W{1'b0}}) begin
            lfsr_s = SEED;
        end else begin
            lfsr_s = {lfsr_r[LFSR_W-2:0], lfsr_fb(lfsr_r)};
        end
`endif
    end

    // FSM next state, attempt counter and coordinate-latch strobe.
    always_comb begin
        state_s   = state_r;
        try_cnt_s = try_cnt_r;
        load_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (req) begin
                    state_s   = DRAW;
                    try_cnt_s = {TRY_W{1'b0}};
                end else begin
                    state_s   = IDLE;
                end
            end
            DRAW: begin
                if (x_in_s && y_in_s) begin
                    load_s  = 1'b1;
                    state_s = DONE;
                end else if (try_cnt_r == TRY_LAST) begin
                    load_s  = 1'b1;
                    state_s = DONE;
                end else begin
                    try_cnt_s = try_cnt_r + TRY_W'(1);
                    state_s   = DRAW;
                end
            end
            DONE: begin
                if (req) begin
                    state_s   = DRAW;
                    try_cnt_s = {TRY_W{1'b0}};
                end else begin
                    state_s   = IDLE;
                end
            end
            default: begin
                state_s   = IDLE;
                try_cnt_s = {TRY_W{1'b0}};
            end
        endcase
    end

    // LFSR register; shifts every cycle regardless of FSM state.
    always_ff @(posedge VGA_clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_r <= SEED;
        end else begin
            lfsr_r <= lfsr_s;
        end
    end

    // FSM state and attempt counter registers.
    always_ff @(posedge VGA_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            try_cnt_r <= {TRY_W{1'b0}};
        end else begin
            state_r   <= state_s;
            try_cnt_r <= try_cnt_s;
        end
    end

    // Output registers; valid/busy track the state being entered, so they are
    // high exactly while the FSM sits in DONE/DRAW.
    always_ff @(posedge VGA_clk or negedge rst_n) begin
        if (!rst_n) begin
            rand_x_r <= X_W'(X_MIN);
            rand_y_r <= Y_W'(Y_MIN);
            valid_r  <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            if (load_s) begin
                rand_x_r <= x_calc_s;
                rand_y_r <= y_calc_s;
            end
            valid_r <= (state_s == DONE);
            busy_r  <= (state_s == DRAW);
        end
    end

    assign rand_X = rand_x_r;
    assign rand_Y = rand_y_r;
    assign valid  = valid_r;
    assign busy   = busy_r;

endmodule
